ask_byte_deframer: RTL

//  Downstream stage of symbol_syncroniser, running in the sampleclk domain.

---
 rtl/ask_byte_deframer_if.sv | 11 +
 rtl/ask_byte_deframer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ask_byte_deframer_if.sv
// Payload byte stream leaving the deframer: FIFO head byte with a
// valid/ready handshake. master = deframer side, slave = consumer side.
`timescale 1ns/1ps
interface ask_byte_deframer_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/ask_byte_deframer.sv
// ask_byte_deframer: samples one bit per symbol from the syncroniser's gated
// symbol clock, assembles a length-prefixed frame and pushes the payload
// bytes into a small FIFO read out through a valid/ready interface.
`timescale 1ns/1ps
module ask_byte_deframer #(
  parameter int SAMPLES_PER_SYMBOL = 4,
  parameter int SAMPLE_PHASE       = 1,
  parameter int WATCHDOG_SYMBOLS   = 4,
  parameter int MAX_LEN            = 64,
  parameter int FIFO_DEPTH         = 4,
  parameter bit MSB_FIRST          = 1'b1
) (
  input  logic                        sampleclk,
  input  logic                        reset,
  input  logic                        serialin,
  input  logic                        symbclk_in,
  input  logic                        lock,
  ask_byte_deframer_if.master         dout,
  output logic [7:0]                  len_out,
  output logic                        frame_start,
  output logic                        frame_end,
  output logic                        frame_abort,
  output logic                        len_error,
  output logic                        overflow
);

  localparam int WD_LIMIT = WATCHDOG_SYMBOLS * SAMPLES_PER_SYMBOL;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);
  localparam int PH_W     = $clog2(SAMPLES_PER_SYMBOL + 1);
  localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW       = AW + 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          symb_q;
  logic          rise;
  logic          strobe;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_new;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    remaining_q, remaining_d;
  logic [7:0]    len_q, len_d;
  logic          start_q, start_d;
  logic          end_q, end_d;
  logic          abort_q, abort_d;
  logic          lenerr_q, lenerr_d;
  logic          overflow_q, overflow_d;
  logic [WD_W-1:0] wd_q;
  logic          wd_expired;
  logic          in_frame;
  logic          push_req;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q;
  logic          full, push, pop;

  // Symbol clock edge detector
  always_ff @(posedge sampleclk or posedge reset) begin
    if (reset) symb_q <= 1'b0;
    else       symb_q <= symbclk_in;
  end

  assign rise = symbclk_in & ~symb_q;

  // Bit strobe: SAMPLE_PHASE cycles after each rise; a new rise restarts the delay
  generate
    if (SAMPLE_PHASE == 0) begin : g_no_phase
      assign strobe = rise;
    end else begin : g_phase
      logic            pend_q;
      logic [PH_W-1:0] ph_q;
      // Delay counter between the detected rise and the sampling point
      always_ff @(posedge sampleclk or posedge reset) begin
        if (reset) begin
          pend_q <= 1'b0;
          ph_q   <= '0;
        end else if (rise) begin
          pend_q <= 1'b1;
          ph_q   <= PH_W'(SAMPLE_PHASE - 1);
        end else if (pend_q) begin
          if (ph_q == '0) pend_q <= 1'b0;
          else            ph_q   <= ph_q - PH_W'(1);
        end
      end
      assign strobe = pend_q && (ph_q == '0);
    end
  endgenerate

  // Byte value including the bit sampled this cycle
  assign byte_new = MSB_FIRST ? {shift_q[6:0], serialin} : {serialin, shift_q[7:1]};

  assign in_frame   = (state_q == S_LEN) || (state_q == S_PAYLOAD);
  assign wd_expired = (wd_q >= WD_W'(WD_LIMIT));

  // Watchdog: cycles since the last symbol clock rise while a frame is open
  always_ff @(posedge sampleclk or posedge reset) begin
    if (reset)                   wd_q <= '0;
    else if (rise || !in_frame)  wd_q <= '0;
    else if (!wd_expired)        wd_q <= wd_q + WD_W'(1);
  end

  // Frame FSM next state, byte assembly and event pulses
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    start_d     = 1'b0;
    end_d       = 1'b0;
    abort_d     = 1'b0;
    lenerr_d    = 1'b0;
    push_req    = 1'b0;
    case (state_q)
      S_IDLE: begin
        bitcnt_d = 3'd0;
        if (strobe && lock) begin
          shift_d  = byte_new;
          bitcnt_d = 3'd1;
          state_d  = S_LEN;
        end
      end
      S_LEN: begin
        if (!lock || wd_expired) begin
          abort_d  = 1'b1;
          state_d  = S_IDLE;
          bitcnt_d = 3'd0;
          shift_d  = 8'd0;
        end else if (strobe) begin
          shift_d  = byte_new;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (byte_new == 8'd0 || byte_new > MAX_LEN_B) begin
              lenerr_d = 1'b1;
              state_d  = S_DONE;
            end else begin
              len_d       = byte_new;
              remaining_d = byte_new;
              start_d     = 1'b1;
              state_d     = S_PAYLOAD;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (!lock || wd_expired) begin
          abort_d  = 1'b1;
          state_d  = S_IDLE;
          bitcnt_d = 3'd0;
          shift_d  = 8'd0;
        end else if (strobe) begin
          shift_d  = byte_new;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            push_req = 1'b1;
            // remaining is always >= 1 here because a zero length never loads
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              end_d   = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        bitcnt_d = 3'd0;
        if (!lock) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame FSM state and registered event outputs
  always_ff @(posedge sampleclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= 8'd0;
      bitcnt_q    <= 3'd0;
      remaining_q <= 8'd0;
      len_q       <= 8'd0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      abort_q     <= 1'b0;
      lenerr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      start_q     <= start_d;
      end_q       <= end_d;
      abort_q     <= abort_d;
      lenerr_q    <= lenerr_d;
    end
  end

  // FIFO control: a pop frees the slot a same-cycle push needs when full
  assign pop        = valid_q && dout.data_ready;
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign push       = push_req && (!full || pop);
  assign overflow_d = overflow_q | (push_req && full && !pop);
  assign count_d    = count_q + CW'(push) - CW'(pop);

  // FIFO storage, one register per entry
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
      // Entry gi captures the payload byte when the write pointer selects it
      always_ff @(posedge sampleclk or posedge reset) begin
        if (reset)                                mem_q[gi] <= 8'd0;
        else if (push && (wr_ptr_q == AW'(gi)))   mem_q[gi] <= byte_new;
      end
    end
  endgenerate

  // FIFO pointers, occupancy, valid flag and sticky overflow
  always_ff @(posedge sampleclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      valid_q    <= (count_d != '0);
      overflow_q <= overflow_d;
    end
  end

  assign dout.data_out   = mem_q[rd_ptr_q];
  assign dout.data_valid = valid_q;
  assign len_out         = len_q;
  assign frame_start     = start_q;
  assign frame_end       = end_q;
  assign frame_abort     = abort_q;
  assign len_error       = lenerr_q;
  assign overflow        = overflow_q;

endmodule
